// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI shift engine.
// The SPI_LSB_FIRST_EN macro selects LSB-first bit ordering in tx_bit().
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        START = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } spi_state_e;

    localparam int   SPI_BITS = 8;
    localparam logic CPHA_0   = 1'b0;
    localparam logic CPHA_1   = 1'b1;

    // TX bit driven for serial position pos (0 = first bit on the wire)
    function automatic logic tx_bit(input logic [7:0] data, input logic [2:0] pos);
`ifdef SPI_LSB_FIRST_EN
        return data[pos];
`else
        return data[3'd7 - pos];
`endif
    endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Byte-level SPI shift engine driven by the clock divider's edge pulses.
// Build option: SPI_LSB_FIRST_EN shifts TX/RX least-significant bit first.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter logic        CPHA           = CPHA_0,
    parameter int unsigned CS_IDLE_CYCLES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_busy,
    output logic       o_div_start_n,
    input  logic       i_div_ready,
    input  logic       i_rising_edge,
    input  logic       i_falling_edge,
    output logic       o_mosi,
    input  logic       i_miso,
    output logic       o_cs_n
);

    localparam logic [3:0] GUARD_INIT = 4'(CS_IDLE_CYCLES);
    localparam logic [3:0] BITS4      = 4'(SPI_BITS);

    spi_state_e state_r;
    logic [7:0] tx_data_r;
    logic [7:0] rx_shift_r;
    logic [7:0] rx_data_r;
    logic [3:0] bit_cnt_r;
    logic [3:0] guard_r;
    logic       cs_n_r;
    logic       mosi_r;
    logic       rx_valid_r;
    logic       div_start_n_r;
    logic       busy_r;
    logic       sample_s;
    logic       shift_s;
    logic       tx_ready_s;

    // Map divider edges onto sample/shift roles and derive readiness
    always_comb begin
        if (CPHA == CPHA_0) begin
            sample_s = i_rising_edge;
            shift_s  = i_falling_edge;
        end else begin
            sample_s = i_falling_edge;
            shift_s  = i_rising_edge;
        end
        tx_ready_s = (state_r == IDLE) && i_div_ready && (guard_r == 4'd0);
    end

    // Frame sequencing, shift registers, counters and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= IDLE;
            tx_data_r     <= 8'h00;
            rx_shift_r    <= 8'h00;
            rx_data_r     <= 8'h00;
            bit_cnt_r     <= 4'd0;
            guard_r       <= 4'd0;
            cs_n_r        <= 1'b1;
            mosi_r        <= 1'b0;
            rx_valid_r    <= 1'b0;
            div_start_n_r <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            rx_valid_r    <= 1'b0;
            div_start_n_r <= 1'b1;
            case (state_r)
                IDLE: begin
                    if (guard_r != 4'd0) begin
                        guard_r <= guard_r - 4'd1;
                    end
                    if (i_tx_valid && tx_ready_s) begin
                        tx_data_r <= i_tx_data;
                        cs_n_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        mosi_r    <= (CPHA == CPHA_0) ? tx_bit(i_tx_data, 3'd0) : 1'b0;
                        state_r   <= SETUP;
                    end
                end
                SETUP: begin
                    // Strobe is registered, so it is low for the whole START cycle
                    div_start_n_r <= 1'b0;
                    state_r       <= START;
                end
                START: begin
                    bit_cnt_r <= 4'd0;
                    state_r   <= SHIFT;
                end
                SHIFT: begin
                    if (sample_s && (bit_cnt_r < BITS4)) begin
`ifdef SPI_LSB_FIRST_EN
                        rx_shift_r <= {i_miso, rx_shift_r[7:1]};
`else
                        rx_shift_r <= {rx_shift_r[6:0], i_miso};
`endif
                        bit_cnt_r  <= bit_cnt_r + 4'd1;
                    end
                    // Serial position equals samples taken so far in both phases
                    if (shift_s && (bit_cnt_r < BITS4)) begin
                        mosi_r <= tx_bit(tx_data_r, bit_cnt_r[2:0]);
                    end
                    if ((bit_cnt_r == BITS4) && i_div_ready) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    rx_data_r  <= rx_shift_r;
                    rx_valid_r <= 1'b1;
                    cs_n_r     <= 1'b1;
                    mosi_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    guard_r    <= GUARD_INIT;
                    state_r    <= IDLE;
                end
                default: begin
                    cs_n_r  <= 1'b1;
                    mosi_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_tx_ready    = tx_ready_s;
    assign o_rx_data     = rx_data_r;
    assign o_rx_valid    = rx_valid_r;
    assign o_busy        = busy_r;
    assign o_div_start_n = div_start_n_r;
    assign o_mosi        = mosi_r;
    assign o_cs_n        = cs_n_r;

endmodule
